// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and pointer-synchroniser blocks.
// Functions operate at MAX_WIDTH; callers zero-extend inputs and truncate results.
package gray_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int unsigned i = MAX_WIDTH - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decoder; bit i is the XOR of gray[WIDTH-1:i].
module gray_decode
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gray2bin(MAX_WIDTH'(gray)));
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs, binary/Gray load,
// wrap or saturate at the range ends, and a one-cycle terminal-count pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0,
    parameter bit          WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RST_BIN)));
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] nxt_bin;
    logic             nxt_tc;

    gray_decode #(.WIDTH(WIDTH)) u_load_decode (
        .gray (load_val),
        .bin  (load_bin)
    );

    // tc flags both a wrap and a blocked saturating step: any attempt to leave the range.
    always_comb begin
        nxt_bin = bin_out;
        nxt_tc  = 1'b0;
        if (load) begin
            nxt_bin = load_is_gray ? load_bin : load_val;
        end else if (en) begin
            if (up) begin
                if (bin_out == MAX_VAL) begin
                    nxt_tc = 1'b1;
                    if (WRAP) nxt_bin = '0;
                end else begin
                    nxt_bin = bin_out + WIDTH'(1);
                end
            end else begin
                if (bin_out == '0) begin
                    nxt_tc = 1'b1;
                    if (WRAP) nxt_bin = MAX_VAL;
                end else begin
                    nxt_bin = bin_out - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= RST_BIN;
            gray_out <= RST_GRAY;
            tc       <= 1'b0;
        end else begin
            bin_out  <= nxt_bin;
            gray_out <= WIDTH'(bin2gray(MAX_WIDTH'(nxt_bin)));
            tc       <= nxt_tc;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (4-bit wrap, 4-bit saturate with
// reset value 5, 6-bit wrap) checked against an integer reference model.
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, en, up, load, lg;
    logic [5:0] lv [3];
    logic [3:0] bin0, gray0, bin1, gray1;
    logic [5:0] bin2, gray2;
    logic [2:0] tcv;

    int checks = 0;
    int errors = 0;
    int m  [3];
    bit mt [3];

    gray_counter #(.WIDTH(4), .RESET_VAL(0), .WRAP(1'b1)) dut0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .load(load[0]),
        .load_is_gray(lg[0]), .load_val(lv[0][3:0]),
        .bin_out(bin0), .gray_out(gray0), .tc(tcv[0]));

    gray_counter #(.WIDTH(4), .RESET_VAL(5), .WRAP(1'b0)) dut1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .load(load[1]),
        .load_is_gray(lg[1]), .load_val(lv[1][3:0]),
        .bin_out(bin1), .gray_out(gray1), .tc(tcv[1]));

    gray_counter #(.WIDTH(6), .RESET_VAL(0), .WRAP(1'b1)) dut2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]), .load(load[2]),
        .load_is_gray(lg[2]), .load_val(lv[2]),
        .bin_out(bin2), .gray_out(gray2), .tc(tcv[2]));

    function automatic int w_of(input int d);
        return (d == 2) ? 6 : 4;
    endfunction

    function automatic bit wrap_of(input int d);
        return d != 1;
    endfunction

    function automatic int rv_of(input int d);
        return (d == 1) ? 5 : 0;
    endfunction

    function automatic logic [31:0] bin_of(input int d);
        return (d == 0) ? 32'(bin0) : (d == 1) ? 32'(bin1) : 32'(bin2);
    endfunction

    function automatic logic [31:0] gray_of(input int d);
        return (d == 0) ? 32'(gray0) : (d == 1) ? 32'(gray1) : 32'(gray2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic; Gray loads decoded by searching for
    // the binary value whose encoding matches.
    task automatic model_step(input int d);
        int maxv;
        int n;
        maxv  = (1 << w_of(d)) - 1;
        mt[d] = 1'b0;
        if (rst[d]) begin
            m[d] = rv_of(d);
        end else if (load[d]) begin
            if (lg[d]) begin
                for (int b = 0; b <= maxv; b++)
                    if ((b ^ (b >> 1)) == (int'(lv[d]) & maxv)) m[d] = b;
            end else begin
                m[d] = int'(lv[d]) & maxv;
            end
        end else if (en[d]) begin
            n = up[d] ? m[d] + 1 : m[d] - 1;
            if (n < 0 || n > maxv) begin
                mt[d] = 1'b1;
                if (wrap_of(d)) m[d] = (n < 0) ? maxv : 0;
            end else begin
                m[d] = n;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            model_step(d);
            check($sformatf("bin%0d", d), bin_of(d), 32'(m[d]));
            check($sformatf("gray%0d", d), gray_of(d), 32'(m[d] ^ (m[d] >> 1)));
            check($sformatf("tc%0d", d), 32'(tcv[d]), 32'(mt[d]));
        end
    endtask

    task automatic idle();
        rst = '0; en = '0; up = '0; load = '0; lg = '0;
        for (int d = 0; d < 3; d++) lv[d] = '0;
    endtask

    task automatic do_load(input int d, input int v, input bit g);
        idle();
        load[d] = 1'b1;
        lg[d]   = g;
        lv[d]   = 6'(v);
    endtask

    task automatic do_step(input int d, input bit dir);
        idle();
        en[d] = 1'b1;
        up[d] = dir;
    endtask

    initial begin
        int ld_vals [4];
        logic [3:0] ld_gray [4];
        logic [5:0] prev;
        int pulses;
        int r;

        ld_vals = '{8, 4, 11, 12};
        ld_gray = '{4'b1100, 4'b0110, 4'b1110, 4'b1010};

        idle();
        rst = '1;
        cycle();
        check("rst_val_sat", 32'(bin1), 32'd5);
        check("rst_gray_sat", 32'(gray1), 32'd7);

        for (int i = 0; i < 4; i++) begin
            do_load(0, ld_vals[i], 1'b0);
            cycle();
            check($sformatf("load_gray_%0d", ld_vals[i]), 32'(gray0), 32'(ld_gray[i]));
        end

        do_load(0, 4'b1110, 1'b1);
        cycle();
        check("gray_load_bin", 32'(bin0), 32'd11);
        prev = 6'(gray0);
        do_step(0, 1'b1);
        cycle();
        check("after_gray_load_bin", 32'(bin0), 32'd12);
        check("after_gray_load_gray", 32'(gray0), 32'b1010);
        check("after_gray_load_onebit", 32'($countones(prev[3:0] ^ gray0)), 32'd1);

        do_load(0, 15, 1'b0);
        cycle();
        do_step(0, 1'b1);
        cycle();
        check("wrap_up_bin", 32'(bin0), 32'd0);
        check("wrap_up_tc", 32'(tcv[0]), 32'd1);
        idle();
        cycle();
        check("wrap_up_tc_pulse", 32'(tcv[0]), 32'd0);
        do_load(0, 0, 1'b0);
        cycle();
        do_step(0, 1'b0);
        cycle();
        check("wrap_dn_bin", 32'(bin0), 32'd15);
        check("wrap_dn_gray", 32'(gray0), 32'b1000);
        check("wrap_dn_tc", 32'(tcv[0]), 32'd1);

        do_load(1, 14, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            do_step(1, 1'b1);
            cycle();
            check($sformatf("sat_bin_%0d", i), 32'(bin1), 32'd15);
            check($sformatf("sat_tc_%0d", i), 32'(tcv[1]), (i == 0) ? 32'd0 : 32'd1);
        end
        do_load(1, 1, 1'b0);
        cycle();
        do_step(1, 1'b0);
        cycle();
        do_step(1, 1'b0);
        cycle();
        check("sat_lo_bin", 32'(bin1), 32'd0);
        check("sat_lo_tc", 32'(tcv[1]), 32'd1);

        do_load(0, 5, 1'b0);
        en[0] = 1'b1; up[0] = 1'b1;
        cycle();
        check("load_over_en_bin", 32'(bin0), 32'd5);
        check("load_over_en_tc", 32'(tcv[0]), 32'd0);
        do_load(1, 9, 1'b0);
        en[1] = 1'b1; up[1] = 1'b1; rst[1] = 1'b1;
        cycle();
        check("rst_over_load_bin", 32'(bin1), 32'd5);

        idle();
        rst[2] = 1'b1;
        cycle();
        pulses = 0;
        for (int i = 0; i < 64 + 3; i++) begin
            prev = gray2;
            do_step(2, 1'b1);
            cycle();
            check("free_hamming", 32'($countones(prev ^ gray2)), 32'd1);
            if (tcv[2]) pulses++;
        end
        check("free_tc_pulses", 32'(pulses), 32'd1);

        for (int i = 0; i < 400; i++) begin
            idle();
            for (int d = 0; d < 3; d++) begin
                r = int'($urandom_range(0, 99));
                rst[d]  = (r < 3);
                load[d] = (r < 15);
                lg[d]   = 1'($urandom);
                lv[d]   = 6'($urandom);
                en[d]   = (r < 85);
                up[d]   = 1'($urandom);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
